// File: rtl/subtractor_operand_sequencer.sv
// Operand-entry sequencer around the combinational 4-bit full subtractor.
// A 2-flop synchroniser and a level debouncer turn the raw push button into
// a one-cycle press pulse. The pulse steps an FSM that captures the minuend
// and subtrahend from the slide switches and then registers difference/borrow.
// Optional build macro: SEQ_RESULT_MAGNITUDE_EN makes the result sign-magnitude
// instead of the raw two's-complement difference.
module subtractor_operand_sequencer #(
    parameter int unsigned STABLE_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic       btn,
    input  logic [3:0] difference,
    input  logic       borrow_out,
    output logic [3:0] minuend,
    output logic [3:0] subtrahend,
    output logic       borrow_in,
    output logic [3:0] result,
    output logic       result_neg,
    output logic       result_valid,
    output logic [1:0] state
);

    localparam int unsigned CNT_W = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_A = 2'b00,
        WAIT_B = 2'b01,
        CALC   = 2'b10,
        SHOW   = 2'b11
    } state_t;

    logic             sync_q1;
    logic             sync_s;
    logic [CNT_W-1:0] db_cnt;
    logic             stable_level;
    logic             press;
    state_t           cur_state;
    state_t           nxt_state;
    logic             load_a;
    logic             load_b;
    logic             do_calc;
    logic [3:0]       calc_value;

    assign borrow_in = 1'b0;
    assign state     = cur_state;

    // Two-flop synchroniser for the asynchronous button
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_s  <= 1'b0;
        end else begin
            sync_q1 <= btn;
            sync_s  <= sync_q1;
        end
    end

    // Debounce: accept a new level after STABLE_CYCLES consecutive differing cycles;
    // press is raised on the same edge that accepts a 0->1 change
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt       <= '0;
            stable_level <= 1'b0;
            press        <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync_s != stable_level) begin
                if (db_cnt == CNT_LAST) begin
                    stable_level <= sync_s;
                    db_cnt       <= '0;
                    press        <= sync_s;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= WAIT_A;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // FSM next-state logic; presses during CALC are dropped
    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            WAIT_A:  if (press) nxt_state = WAIT_B;
            WAIT_B:  if (press) nxt_state = CALC;
            CALC:    nxt_state = SHOW;
            SHOW:    if (press) nxt_state = WAIT_B;
            default: nxt_state = WAIT_A;
        endcase
    end

    // FSM output decode into datapath load strobes
    always_comb begin
        load_a  = 1'b0;
        load_b  = 1'b0;
        do_calc = 1'b0;
        case (cur_state)
            WAIT_A:  load_a  = press;
            WAIT_B:  load_b  = press;
            CALC:    do_calc = 1'b1;
            SHOW:    load_a  = press;
            default: ;
        endcase
    end

    // Result formatting taken from the subtractor outputs
    always_comb begin
`ifdef SEQ_RESULT_MAGNITUDE_EN
        calc_value = borrow_out ? (~difference + 4'd1) : difference;
`else
        calc_value = difference;
`endif
    end

    // Operand and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            minuend      <= '0;
            subtrahend   <= '0;
            result       <= '0;
            result_neg   <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            if (load_a) begin
                minuend      <= sw;
                result_valid <= 1'b0;
            end
            if (load_b) begin
                subtrahend <= sw;
            end
            if (do_calc) begin
                result       <= calc_value;
                result_neg   <= borrow_out;
                result_valid <= 1'b1;
            end
        end
    end

endmodule
